street_light_scheduler: RTL and testbench

STREET_LIGHT_SCHEDULER -- requirements
Module: street_light_scheduler

---
 rtl/street_light_pkg.sv | 34 +++
 rtl/button_sync_edge.sv | 33 +++
 rtl/street_light_scheduler.sv | 117 +++++++++++
 tb/tb_street_light_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/street_light_pkg.sv
// Shared encodings, defaults and small helpers for the street light scheduler.
package street_light_pkg;

  localparam int unsigned DEF_STAGGER = 4;
  localparam int unsigned DEF_HOLD    = 16;
  localparam int          CNT_W       = 8;
  localparam int          NUM_LIGHTS  = 4;

  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [NUM_LIGHTS-1:0] lamp_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  // Terminal count for a wait of 'cycles' clocks (counter runs 0..cycles-1).
  function automatic cnt_t last_count(input int unsigned cycles);
    return cnt_t'(cycles - 1);
  endfunction

  // True when the lit lamps form a contiguous run starting at light (bit 0).
  function automatic logic low_run(input lamp_t v);
    return (v & (v + lamp_t'(1))) == '0;
  endfunction

  // True when the lit lamps form a contiguous run ending at light4 (top bit).
  function automatic logic high_run(input lamp_t v);
    return low_run(~v);
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer with rising-edge detect; a level already high out of
// reset must drop once before it can produce a press.
module button_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [1:0] sync;
  logic       prev;
  logic [1:0] vld_pipe;
  logic       armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      prev     <= 1'b0;
      vld_pipe <= '0;
      armed    <= 1'b0;
    end else begin
      sync     <= {sync[0], din};
      prev     <= sync[1];
      vld_pipe <= {vld_pipe[0], 1'b1};
      // Arm only on a genuine low seen after the reset-cleared flops flushed.
      if (vld_pipe[1] && !sync[1])
        armed <= 1'b1;
    end
  end

  assign rise = armed & sync[1] & ~prev;

endmodule

// File: rtl/street_light_scheduler.sv
// Presence-triggered street light sequencer: staggered ramp-up of four lamps,
// a retriggerable hold, then staggered ramp-down back to idle.
module street_light_scheduler
  import street_light_pkg::*;
#(
  parameter int unsigned STAGGER = DEF_STAGGER,
  parameter int unsigned HOLD    = DEF_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b,
  output logic       light,
  output logic       light2,
  output logic       light3,
  output logic       light4,
  output logic       busy,
  output logic [1:0] state
);

  localparam cnt_t STG_LAST  = last_count(STAGGER);
  localparam cnt_t HOLD_LAST = last_count(HOLD);

  logic   press;
  state_e cur;
  cnt_t   cnt;
  lamp_t  lamps;

  button_sync_edge u_btn (
    .clk  (clk),
    .rst  (rst),
    .din  (b),
    .rise (press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur   <= ST_IDLE;
      cnt   <= '0;
      lamps <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (cur)
        ST_IDLE: begin
          cnt   <= '0;
          lamps <= '0;
          if (press) begin
            cur   <= ST_RAMP_UP;
            lamps <= lamp_t'(1);
            busy  <= 1'b1;
          end
        end
        ST_RAMP_UP: begin
          if (cnt == STG_LAST) begin
            cnt   <= '0;
            lamps <= {lamps[NUM_LIGHTS-2:0], 1'b1};
            if (lamps[NUM_LIGHTS-2])
              cur <= ST_HOLD;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        ST_HOLD: begin
          if (press) begin
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            cnt      <= '0;
            lamps[0] <= 1'b0;
            cur      <= ST_RAMP_DOWN;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        ST_RAMP_DOWN: begin
          if (press) begin
            cnt   <= '0;
            lamps <= '1;
            cur   <= ST_HOLD;
          end else if (cnt == STG_LAST) begin
            cnt   <= '0;
            lamps <= {lamps[NUM_LIGHTS-2:0], 1'b0};
            // Only light4 left means this step darkens the last lamp.
            if (!lamps[NUM_LIGHTS-2]) begin
              cur  <= ST_IDLE;
              busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        default: begin
          cur   <= ST_IDLE;
          cnt   <= '0;
          lamps <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign {light4, light3, light2, light} = lamps;
  assign state = cur;

  // Lamp pattern must always be consistent with the phase it is in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_busy: assert (busy == (cur != ST_IDLE));
      unique case (cur)
        ST_IDLE:      a_idle: assert (lamps == '0);
        ST_RAMP_UP:   a_up:   assert (low_run(lamps) && lamps[0] && !lamps[NUM_LIGHTS-1]);
        ST_HOLD:      a_hold: assert (lamps == '1);
        ST_RAMP_DOWN: a_down: assert (high_run(lamps) && !lamps[0] && lamps[NUM_LIGHTS-1]);
        default:      a_enc:  assert (1'b0);
      endcase
    end
  end

endmodule

// File: tb/tb_street_light_scheduler.sv
// Bench: three parameterizations driven in parallel, checked every cycle
// against a timeline model (phase + elapsed time), plus pinned edge literals.
module tb_street_light_scheduler;
  import street_light_pkg::*;

  localparam int N = 3;
  localparam int STG [N] = '{4, 1, 3};
  localparam int HLD [N] = '{16, 1, 5};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b   = 1'b0;

  logic [N-1:0][3:0] lamps;
  logic [N-1:0]      busy;
  logic [N-1:0][1:0] st;

  street_light_scheduler #(.STAGGER(STG[0]), .HOLD(HLD[0])) u_def (
    .clk(clk), .rst(rst), .b(b),
    .light(lamps[0][0]), .light2(lamps[0][1]), .light3(lamps[0][2]), .light4(lamps[0][3]),
    .busy(busy[0]), .state(st[0]));

  street_light_scheduler #(.STAGGER(STG[1]), .HOLD(HLD[1])) u_fast (
    .clk(clk), .rst(rst), .b(b),
    .light(lamps[1][0]), .light2(lamps[1][1]), .light3(lamps[1][2]), .light4(lamps[1][3]),
    .busy(busy[1]), .state(st[1]));

  street_light_scheduler #(.STAGGER(STG[2]), .HOLD(HLD[2])) u_odd (
    .clk(clk), .rst(rst), .b(b),
    .light(lamps[2][0]), .light2(lamps[2][1]), .light3(lamps[2][2]), .light4(lamps[2][3]),
    .busy(busy[2]), .state(st[2]));

  always #5 clk = ~clk;

  // Model: phase (0 idle, 1 up, 2 hold, 3 down) and cycles spent in it.
  typedef struct { int mode; int t; } mdl_t;
  mdl_t m [N];
  logic [N-1:0][3:0] exp_lamps;
  logic [N-1:0][1:0] exp_st;
  logic [N-1:0]      exp_busy;

  bit bs [65536];
  int k        = 0;
  int last_rst = 0;
  bit press;
  int n_chk    = 0;
  int n_fail   = 0;

  function automatic void step(inout mdl_t s, input int stg, input int hld, input bit p);
    case (s.mode)
      0: if (p) begin s.mode = 1; s.t = 0; end
      1: begin
        s.t++;
        if (s.t == 3 * stg) begin s.mode = 2; s.t = 0; end
      end
      2: if (p) s.t = 0;
         else begin
           s.t++;
           if (s.t == hld) begin s.mode = 3; s.t = 0; end
         end
      default: if (p) begin s.mode = 2; s.t = 0; end
         else begin
           s.t++;
           if (s.t == 3 * stg) begin s.mode = 0; s.t = 0; end
         end
    endcase
  endfunction

  function automatic logic [3:0] lit(input mdl_t s, input int stg);
    logic [3:0] v;
    int n;
    v = '0;
    n = 1 + s.t / stg;
    for (int i = 0; i < 4; i++)
      case (s.mode)
        1:       v[i] = (i < n);
        2:       v[i] = 1'b1;
        3:       v[i] = (i >= n);
        default: v[i] = 1'b0;
      endcase
    return v;
  endfunction

  always @(posedge clk) begin
    k++;
    bs[k] = b;
    if (rst) begin
      last_rst = k;
      for (int i = 0; i < N; i++) begin m[i].mode = 0; m[i].t = 0; end
    end else begin
      // Press acted on two edges after b is first sampled high, provided the
      // preceding low sample was taken after reset.
      press = (k >= 4) && (k - 3 > last_rst) && bs[k-2] && !bs[k-3];
      for (int i = 0; i < N; i++) step(m[i], STG[i], HLD[i], press);
    end
    for (int i = 0; i < N; i++) begin
      exp_lamps[i] = lit(m[i], STG[i]);
      exp_st[i]    = 2'(m[i].mode);
      exp_busy[i]  = (m[i].mode != 0);
    end
  end

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d edge %0d: got %h expected %h", nm, idx, k, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (k >= 1)
      for (int i = 0; i < N; i++) begin
        chk("lamps", i, lamps[i], exp_lamps[i]);
        chk("state", i, 4'(st[i]), 4'(exp_st[i]));
        chk("busy",  i, 4'(busy[i]), 4'(exp_busy[i]));
      end
  end

  task automatic wait_to(input int e);
    while (k < e) begin @(posedge clk); #1; end
  endtask

  // Make the value sampled at edge e equal v.
  task automatic set_b(input int e, input bit v);
    wait_to(e - 1);
    b = v;
  endtask

  task automatic set_rst(input int e, input bit v);
    wait_to(e - 1);
    rst = v;
  endtask

  task automatic pin(input int e, input int i, input logic [3:0] wl, input logic [1:0] ws);
    wait_to(e);
    chk("pin_lamps", i, lamps[i], wl);
    chk("pin_model", i, exp_lamps[i], wl);
    chk("pin_state", i, 4'(st[i]), 4'(ws));
    chk("pin_busy",  i, 4'(busy[i]), 4'(ws != 2'd0));
  endtask

  // Returns the edge number that will be E1 (first high sample of b).
  task automatic settle(output int e1);
    b = 1'b0;
    for (int c = 0; c < 500 && busy != '0; c++) begin @(posedge clk); #1; end
    chk("settle", 0, 4'(busy), 4'd0);
    repeat (4) begin @(posedge clk); #1; end
    e1 = k + 1;
  endtask

  int e1;
  int run;

  initial begin
    wait_to(3);
    rst = 1'b0;

    // Held press: full default schedule and the STAGGER=1/HOLD=1 schedule.
    settle(e1);
    set_b(e1, 1'b1);
    pin(e1+1, 0, 4'b0000, 2'd0);  pin(e1+1, 1, 4'b0000, 2'd0);
    pin(e1+2, 0, 4'b0001, 2'd1);  pin(e1+2, 1, 4'b0001, 2'd1);
    pin(e1+3, 1, 4'b0011, 2'd1);
    pin(e1+4, 1, 4'b0111, 2'd1);
    pin(e1+5, 1, 4'b1111, 2'd2);  pin(e1+5, 0, 4'b0001, 2'd1);
    pin(e1+6, 1, 4'b1110, 2'd3);  pin(e1+6, 0, 4'b0011, 2'd1);
    pin(e1+7, 1, 4'b1100, 2'd3);
    pin(e1+8, 1, 4'b1000, 2'd3);
    pin(e1+9, 1, 4'b0000, 2'd0);
    pin(e1+10, 0, 4'b0111, 2'd1);
    pin(e1+13, 0, 4'b0111, 2'd1);
    pin(e1+14, 0, 4'b1111, 2'd2);
    pin(e1+29, 0, 4'b1111, 2'd2);
    pin(e1+30, 0, 4'b1110, 2'd3);
    pin(e1+34, 0, 4'b1100, 2'd3);
    pin(e1+38, 0, 4'b1000, 2'd3);
    pin(e1+41, 0, 4'b1000, 2'd3);
    pin(e1+42, 0, 4'b0000, 2'd0);

    // Re-press acted on during ramp-up (E9): schedule unchanged.
    settle(e1);
    set_b(e1, 1'b1); set_b(e1+4, 1'b0); set_b(e1+6, 1'b1);
    pin(e1+8, 0, 4'b0011, 2'd1);
    pin(e1+14, 0, 4'b1111, 2'd2);
    pin(e1+30, 0, 4'b1110, 2'd3);
    pin(e1+42, 0, 4'b0000, 2'd0);

    // Retrigger in hold (E25): light drops at E41.
    settle(e1);
    set_b(e1, 1'b1); set_b(e1+4, 1'b0); set_b(e1+22, 1'b1);
    pin(e1+24, 0, 4'b1111, 2'd2);
    pin(e1+30, 0, 4'b1111, 2'd2);
    pin(e1+39, 0, 4'b1111, 2'd2);
    pin(e1+40, 0, 4'b1110, 2'd3);
    pin(e1+52, 0, 4'b0000, 2'd0);

    // Press during ramp-down (E33): all on, hold, light drops at E49.
    settle(e1);
    set_b(e1, 1'b1); set_b(e1+4, 1'b0); set_b(e1+30, 1'b1);
    pin(e1+31, 0, 4'b1110, 2'd3);
    pin(e1+32, 0, 4'b1111, 2'd2);
    pin(e1+47, 0, 4'b1111, 2'd2);
    pin(e1+48, 0, 4'b1110, 2'd3);

    // Reset at E20 with b held: no press until b toggles.
    settle(e1);
    set_b(e1, 1'b1);
    pin(e1+18, 0, 4'b1111, 2'd2);
    rst = 1'b1;
    pin(e1+19, 0, 4'b0000, 2'd0);  pin(e1+19, 1, 4'b0000, 2'd0);
    rst = 1'b0;
    pin(e1+39, 0, 4'b0000, 2'd0);
    set_b(e1+40, 1'b0);
    set_b(e1+42, 1'b1);
    pin(e1+43, 0, 4'b0000, 2'd0);
    pin(e1+44, 0, 4'b0001, 2'd1);

    // Randomized button activity with occasional reset pulses.
    settle(e1);
    run = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (run == 0) begin
        b   = ~b;
        run = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 60 : 6);
      end
      run--;
      rst = ($urandom_range(0, 249) == 0);
    end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", k);
    $fatal(1);
  end

endmodule
